chamber_sequencer: RTL and testbench
====================================

// Module: chamber_sequencer
// PURPOSE
//   Responder side of the airlock command interface. Accepts one-cycle
//   commands issued by the interlock controller (fill/pressurize, evacuate,
//   outer-port toggle, inner-port toggle). Enforces the airlock interlock
//   rules, times the fill and evacuate operations, and returns one
//   completion or rejection response per command. Owns the authoritative
//   port and chamber state, which drives the LEDs and HEX displays.
// PARAMETERS
//   FILL_CYCLES  7  clock cycles spent in FILL (>=1)
//   EVAC_CYCLES  5  clock cycles spent in EVAC (>=1)
//   CNT_W        4  timer width; must hold max(FILL_CYCLES,EVAC_CYCLES)-1
// PORTS
//   Clock         in   1  single design clock; all state on rising edge
//   Reset         in   1  asynchronous, active-low reset
//   cmd_valid     in   1  command present this cycle
//   cmd_op        in   2  00 fill, 01 evacuate, 10 toggle outer, 11 toggle inner
//   cmd_ready     out  1  high only in IDLE
//   rsp_valid     out  1  one-cycle pulse, one per accepted command
//   rsp_err       out  1  command rejected; meaningful only with rsp_valid
//   outer_closed  out  1  1 = outer (water-side) port closed
//   inner_closed  out  1  1 = inner (vessel-side) port closed
//   pressurized   out  1  chamber filled to outside pressure
//   evacuated     out  1  chamber drained to vessel pressure
//   busy          out  1  state is FILL or EVAC
//   state_code    out  3  0 IDLE, 1 FILL, 2 EVAC, 3 RESP (HEX display)
// BEHAVIOUR
//   - Reset (Reset==0, async): state IDLE, timer 0, outer_closed=1,
//     inner_closed=1, evacuated=1, pressurized=0, rsp_valid=0, rsp_err=0.
//   - Accept: cmd_valid && cmd_ready at a rising edge. Inputs are ignored
//     outside IDLE. No queueing. A held cmd_valid is accepted on the first
//     IDLE cycle.
//   - Toggle outer: opening requires inner_closed && pressurized.
//     Toggle inner: opening requires outer_closed && evacuated.
//     Closing a port is always legal. The port output updates at the
//     accept edge; the next cycle is RESP.
//   - Fill/evacuate: requires both ports closed, otherwise rejected.
//     If the chamber is already in the target state: go to RESP, no error,
//     no timing.
//     Otherwise: load timer with N-1 (N = FILL_CYCLES or EVAC_CYCLES) and
//     enter FILL or EVAC. pressurized=0 and evacuated=0 throughout.
//     Decrement the timer each cycle. When the timer is 0: set the target
//     flag, clear the other flag, go to RESP.
//   - Rejection: state unchanged, next cycle RESP with rsp_err=1.
//   - RESP: rsp_valid=1 for exactly one cycle, then IDLE. cmd_ready=0 in
//     RESP.
//   - Latency from accept edge to rsp_valid:
//     toggle/reject/no-op: 1 cycle; fill: FILL_CYCLES+1; evac: EVAC_CYCLES+1.
//   - Invariant: never outer_closed==0 && inner_closed==0.
//   - Reset mid-operation: the in-flight command is dropped, no response is
//     emitted, and all outputs return to reset values immediately.
// STRUCTURE
//   - Shared include airlock_defs.vh:
//     * cmd_op encodings (OP_FILL, OP_EVAC, OP_OUTER, OP_INNER)
//     * state encodings (ST_IDLE, ST_FILL, ST_EVAC, ST_RESP)
//     The interlock controller uses the same include.
//   - One sub-module, chamber_timer: down-counter with load value, load,
//     enable and zero flag, async active-low reset, CNT_W wide.
//   - All FSM and interlock logic is in chamber_sequencer.
// TESTING (FILL_CYCLES=7, EVAC_CYCLES=5)
//   1. Release reset -> outer_closed=1, inner_closed=1, evacuated=1,
//      pressurized=0, cmd_ready=1, rsp_valid=0, state_code=0.
//   2. op=11 from reset -> 1 cycle later rsp_valid=1, rsp_err=0,
//      inner_closed=0. Then op=00 -> rsp_err=1, flags unchanged.
//   3. Close inner, op=00 -> busy=1, state_code=1 for 7 cycles, rsp_valid
//      at accept+8, pressurized=1, evacuated=0.
//   4. From 3, op=10 -> outer_closed=0, no error. Then op=11 -> rsp_err=1,
//      inner_closed stays 1.
//   5. Close outer, op=01, assert Reset 3 cycles in -> immediate reset
//      values, no rsp_valid after release.
//   6. Hold cmd_valid with op=10 through a FILL -> not accepted until IDLE;
//      accepted the cycle after RESP; exactly 2 rsp_valid pulses total.

Source files
------------

// File: rtl/chamber_sequencer_pkg.sv
// chamber_sequencer_pkg: command and state encodings shared by the airlock sequencer and its controller
package chamber_sequencer_pkg;
    typedef enum logic [1:0] {OP_FILL = 2'b00, OP_EVAC = 2'b01, OP_OUTER = 2'b10, OP_INNER = 2'b11} op_t;
    typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_FILL = 2'b01, ST_EVAC = 2'b10, ST_RESP = 2'b11} state_t;
endpackage

// File: rtl/chamber_timer.sv
// chamber_timer: loadable down-counter with zero flag timing fill and evacuate phases
module chamber_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (en) cnt <= cnt - 1'b1;
    assign zero = cnt == '0;
endmodule

// File: rtl/chamber_sequencer.sv
// chamber_sequencer: airlock command responder enforcing port interlocks and timing fill/evacuate
module chamber_sequencer
    import chamber_sequencer_pkg::*;
#(
    parameter int FILL_CYCLES = 7,
    parameter int EVAC_CYCLES = 5,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    output logic       rsp_valid,
    output logic       rsp_err,
    output logic       outer_closed,
    output logic       inner_closed,
    output logic       pressurized,
    output logic       evacuated,
    output logic       busy,
    output logic [2:0] state_code
);
    state_t           state, state_nx;
    logic             outer_nx, inner_nx, press_nx, evac_nx, err_q, err_nx;
    logic             load, en, zero;
    logic [CNT_W-1:0] load_val;
    chamber_timer #(.CNT_W(CNT_W)) u_timer (
        .clk(clk), .rst_n(rst_n), .load(load), .en(en), .load_val(load_val), .zero(zero)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state        <= ST_IDLE;
            outer_closed <= 1'b1;
            inner_closed <= 1'b1;
            pressurized  <= 1'b0;
            evacuated    <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            state        <= state_nx;
            outer_closed <= outer_nx;
            inner_closed <= inner_nx;
            pressurized  <= press_nx;
            evacuated    <= evac_nx;
            err_q        <= err_nx;
        end
    always_comb begin
        state_nx = state;
        outer_nx = outer_closed;
        inner_nx = inner_closed;
        press_nx = pressurized;
        evac_nx  = evacuated;
        err_nx   = err_q;
        load     = 1'b0;
        en       = 1'b0;
        load_val = '0;
        case (state)
            ST_IDLE: if (cmd_valid) begin
                state_nx = ST_RESP;
                err_nx   = 1'b0;
                case (op_t'(cmd_op))
                    OP_OUTER:
                        if (!outer_closed) outer_nx = 1'b1;
                        else if (inner_closed && pressurized) outer_nx = 1'b0;
                        else err_nx = 1'b1;
                    OP_INNER:
                        if (!inner_closed) inner_nx = 1'b1;
                        else if (outer_closed && evacuated) inner_nx = 1'b0;
                        else err_nx = 1'b1;
                    OP_FILL:
                        if (!(outer_closed && inner_closed)) err_nx = 1'b1;
                        else if (!pressurized) begin
                            load     = 1'b1;
                            load_val = CNT_W'(FILL_CYCLES - 1);
                            press_nx = 1'b0;
                            evac_nx  = 1'b0;
                            state_nx = ST_FILL;
                        end
                    default:
                        if (!(outer_closed && inner_closed)) err_nx = 1'b1;
                        else if (!evacuated) begin
                            load     = 1'b1;
                            load_val = CNT_W'(EVAC_CYCLES - 1);
                            press_nx = 1'b0;
                            evac_nx  = 1'b0;
                            state_nx = ST_EVAC;
                        end
                endcase
            end
            ST_FILL, ST_EVAC: begin
                en = !zero;
                if (zero) begin
                    press_nx = state == ST_FILL;
                    evac_nx  = state == ST_EVAC;
                    state_nx = ST_RESP;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end
    assign cmd_ready  = state == ST_IDLE;
    assign rsp_valid  = state == ST_RESP;
    assign rsp_err    = rsp_valid && err_q;
    assign busy       = state == ST_FILL || state == ST_EVAC;
    assign state_code = {1'b0, state};
endmodule

// File: tb/tb_chamber_sequencer.sv
// tb_chamber_sequencer: scoreboard bench driving directed and random airlock commands against a rule-level model
module tb_chamber_sequencer;
    localparam int FILL = 7;
    localparam int EVAC = 5;
    typedef struct {
        int         t;
        int         lat;
        logic [1:0] op;
        logic       err, outer, inner, press, evac;
    } exp_t;
    logic       clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic       cmd_ready, rsp_valid, rsp_err, outer_closed, inner_closed;
    logic       pressurized, evacuated, busy;
    logic [2:0] state_code;
    int         cyc = 0, n_chk = 0, n_fail = 0;
    bit         mon_on = 1'b0;
    bit         m_outer, m_inner, m_press, m_evac;
    exp_t       q[$];
    chamber_sequencer #(.FILL_CYCLES(FILL), .EVAC_CYCLES(EVAC), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .outer_closed(outer_closed), .inner_closed(inner_closed),
        .pressurized(pressurized), .evacuated(evacuated), .busy(busy),
        .state_code(state_code)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    task automatic model_reset();
        m_outer = 1; m_inner = 1; m_press = 0; m_evac = 1;
    endtask
    // Model applies the interlock rules at the accept and records the post-command chamber state.
    task automatic model_accept(input logic [1:0] op);
        exp_t e;
        e.t = cyc; e.lat = 1; e.op = op; e.err = 0;
        case (op)
            2'd0: if (!(m_outer && m_inner)) e.err = 1;
                  else if (!m_press) begin e.lat = FILL + 1; m_press = 1; m_evac = 0; end
            2'd1: if (!(m_outer && m_inner)) e.err = 1;
                  else if (!m_evac) begin e.lat = EVAC + 1; m_evac = 1; m_press = 0; end
            2'd2: if (!m_outer) m_outer = 1;
                  else if (m_inner && m_press) m_outer = 0;
                  else e.err = 1;
            default: if (!m_inner) m_inner = 1;
                  else if (m_outer && m_evac) m_inner = 0;
                  else e.err = 1;
        endcase
        e.outer = m_outer; e.inner = m_inner; e.press = m_press; e.evac = m_evac;
        q.push_back(e);
    endtask
    task automatic issue(input logic [1:0] op);
        int w = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_op = op;
        while (!cmd_ready && w < 60) begin @(negedge clk); w++; end
        if (!cmd_ready) begin
            chk("accept_timeout", 0, 1);
            cmd_valid = 0;
            return;
        end
        model_accept(op);
        @(posedge clk);
        #1 cmd_valid = 0;
    endtask
    task automatic do_reset(input int d);
        repeat (d) @(negedge clk);
        #1 rst_n = 0;
        cmd_valid = 0;
        q.delete();
        model_reset();
        #1;
        chk("rst_outer_closed", outer_closed, 1);
        chk("rst_inner_closed", inner_closed, 1);
        chk("rst_evacuated", evacuated, 1);
        chk("rst_pressurized", pressurized, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_state_code", state_code, 0);
        @(negedge clk);
        #1 rst_n = 1;
    endtask
    always @(negedge clk) if (mon_on) begin
        bit act, ex_rsp, ex_busy;
        int age, code;
        act = q.size() > 0 && cyc > q[0].t;
        age = act ? cyc - q[0].t : 0;
        ex_rsp = act && age == q[0].lat;
        ex_busy = act && age < q[0].lat;
        code = ex_rsp ? 3 : ex_busy ? (q[0].op == 2'd0 ? 1 : 2) : 0;
        chk("cmd_ready", cmd_ready, !act);
        chk("rsp_valid", rsp_valid, ex_rsp);
        chk("busy", busy, ex_busy);
        chk("state_code", state_code, code);
        chk("port_invariant", outer_closed | inner_closed, 1);
        if (ex_busy) begin
            chk("busy_pressurized", pressurized, 0);
            chk("busy_evacuated", evacuated, 0);
        end
        if (ex_rsp) begin
            chk("rsp_err", rsp_err, q[0].err);
            chk("outer_closed", outer_closed, q[0].outer);
            chk("inner_closed", inner_closed, q[0].inner);
            chk("pressurized", pressurized, q[0].press);
            chk("evacuated", evacuated, q[0].evac);
        end
        if (act && age >= q[0].lat) void'(q.pop_front());
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int w;
        model_reset();
        #22 rst_n = 1;
        #1;
        chk("init_outer_closed", outer_closed, 1);
        chk("init_inner_closed", inner_closed, 1);
        chk("init_evacuated", evacuated, 1);
        chk("init_pressurized", pressurized, 0);
        chk("init_cmd_ready", cmd_ready, 1);
        chk("init_rsp_valid", rsp_valid, 0);
        chk("init_state_code", state_code, 0);
        mon_on = 1;
        issue(2'd3);
        issue(2'd0);
        issue(2'd3);
        issue(2'd0);
        issue(2'd2);
        issue(2'd3);
        issue(2'd2);
        issue(2'd1);
        do_reset(2);
        repeat (12) @(negedge clk);
        issue(2'd0);
        issue(2'd2);
        for (int i = 0; i < 300; i++) begin
            issue(2'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            if ($urandom_range(0, 24) == 0) do_reset($urandom_range(0, 6));
        end
        w = 0;
        while (q.size() > 0 && w < 200) begin @(negedge clk); w++; end
        chk("drain_queue", q.size(), 0);
        @(negedge clk);
        mon_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
